// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_write_arbiter.
// The master modport is the arbiter; the slave modport is the surrounding logic.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 128
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]       IN_valid;
  logic [NUM_REQ*WIDTH-1:0] IN_data;
  logic [NUM_REQ-1:0]       OUT_ready;
  logic                     IN_pop;
  logic                     OUT_valid;
  logic [WIDTH-1:0]         OUT_data;
  logic [SRC_W-1:0]         OUT_src;
  logic [CNT_W-1:0]         OUT_count;
  logic                     OUT_full;
  logic                     OUT_underflow;

  modport master (
    input  IN_valid, IN_data, IN_pop,
    output OUT_ready, OUT_valid, OUT_data, OUT_src, OUT_count, OUT_full, OUT_underflow
  );

  modport slave (
    output IN_valid, IN_data, IN_pop,
    input  OUT_ready, OUT_valid, OUT_data, OUT_src, OUT_count, OUT_full, OUT_underflow
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for a FIFO write port with no back-pressure; tracks
// FIFO occupancy with a credit counter so a write is never issued when full.
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_write_arbiter_if.master  bus
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = SRC_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [SUM_W-1:0] NUM_C   = SUM_W'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_C  = SRC_W'(NUM_REQ - 1);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic [SRC_W-1:0] src_q,    src_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             full_q,   full_d;
  logic             under_q,  under_d;

  logic             grant_found;
  logic [SRC_W-1:0] grant_idx;
  logic [SUM_W-1:0] scan_sum;
  logic [SRC_W-1:0] scan_idx;
  logic             accept;
  logic             pop_eff;
  logic [NUM_REQ-1:0] ready;

  // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (scan_sum >= NUM_C) begin
        scan_sum = scan_sum - NUM_C;
      end
      scan_idx = scan_sum[SRC_W-1:0];
      if (!grant_found && bus.IN_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Gating on the registered full flag keeps IN_pop out of the grant path.
  assign accept  = grant_found && !full_q;
  assign pop_eff = bus.IN_pop && (count_q != '0);

  always_comb begin
    ready = '0;
    if (accept) begin
      ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    valid_d  = accept;
    data_d   = data_q;
    src_d    = src_q;
    count_d  = count_q;
    under_d  = under_q;

    if (accept) begin
      data_d   = bus.IN_data[grant_idx*WIDTH +: WIDTH];
      src_d    = grant_idx;
      rr_ptr_d = (grant_idx == LAST_C) ? '0 : grant_idx + SRC_W'(1);
    end

    case ({accept, pop_eff})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (bus.IN_pop && (count_q == '0)) begin
      under_d = 1'b1;
    end

    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      src_q    <= src_d;
      count_q  <= count_d;
      full_q   <= full_d;
      under_q  <= under_d;
    end
  end

  assign bus.OUT_ready     = ready;
  assign bus.OUT_valid     = valid_q;
  assign bus.OUT_data      = data_q;
  assign bus.OUT_src       = src_q;
  assign bus.OUT_count     = count_q;
  assign bus.OUT_full      = full_q;
  assign bus.OUT_underflow = under_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized checks of fifo_write_arbiter against a cycle-level
// behavioural model of occupancy, round-robin order and the write strobe.
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();

  fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  int          m_ptr = 0;
  int          m_src = 0;
  bit          m_valid = 1'b0;
  bit          m_under = 1'b0;
  logic [W-1:0] m_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First requester with a pending request, scanning from the pointer; -1 if none or full.
  function automatic int exp_grant();
    if (m_cnt == D) return -1;
    for (int k = 0; k < N; k++) begin
      if (bus.IN_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic settle();
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", bus.OUT_ready, er);
    chk("valid", bus.OUT_valid, m_valid);
    chk("data", bus.OUT_data, m_data);
    chk("src", bus.OUT_src, m_src);
    chk("count", bus.OUT_count, m_cnt);
    chk("full", bus.OUT_full, m_cnt == D);
    chk("underflow", bus.OUT_underflow, m_under);
  endtask

  task automatic tick();
    int g;
    bit r, p, pe;
    logic [N*W-1:0] dv;
    g  = exp_grant();
    r  = rst;
    p  = bus.IN_pop;
    dv = bus.IN_data;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_ptr = 0; m_src = 0; m_valid = 1'b0; m_under = 1'b0; m_data = '0;
    end else begin
      pe = p && (m_cnt != 0);
      if (p && m_cnt == 0) m_under = 1'b1;
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = dv[g*W +: W];
        m_src  = g;
        m_ptr  = (g + 1) % N;
      end
      m_cnt = m_cnt + ((g >= 0) ? 1 : 0) - (pe ? 1 : 0);
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic new_data();
    bus.IN_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.IN_valid = '0;
    bus.IN_pop   = 1'b0;
    bus.IN_data  = '0;
    @(posedge clk);
    #1;
    settle();
    chk("reset_count", bus.OUT_count, 0);
    chk("reset_valid", bus.OUT_valid, 0);
    tick();
    rst = 1'b0;

    // All requesters valid: strict rotation until the FIFO fills.
    bus.IN_valid = 4'b1111;
    for (int i = 0; i < 132; i++) begin
      new_data();
      settle();
      if (i < 8) chk("t1_rotation", bus.OUT_ready, 64'(1) << (i % 4));
      tick();
    end
    settle();
    chk("t1_full", bus.OUT_full, 1);
    chk("t1_count", bus.OUT_count, 128);
    chk("t1_no_grant", bus.OUT_ready, 0);
    tick();

    // Single pop while full frees exactly one slot, granted the cycle after.
    bus.IN_pop = 1'b1;
    settle();
    chk("t2_pop_cycle_no_grant", bus.OUT_ready, 0);
    tick();
    bus.IN_pop = 1'b0;
    new_data();
    settle();
    chk("t2_count_127", bus.OUT_count, 127);
    chk("t2_one_grant", bus.OUT_ready, 4'b0001);
    tick();
    settle();
    chk("t2_refull", bus.OUT_count, 128);
    chk("t2_no_grant", bus.OUT_ready, 0);
    tick();

    // Sparse requests with pointer at 1.
    do_reset();
    bus.IN_valid = 4'b0001;
    new_data();
    cyc();
    bus.IN_valid = 4'b0101;
    new_data();
    settle(); chk("t3_g2", bus.OUT_ready, 4'b0100); tick();
    new_data();
    settle(); chk("t3_g0", bus.OUT_ready, 4'b0001); tick();
    new_data();
    settle(); chk("t3_g2b", bus.OUT_ready, 4'b0100); tick();
    cyc();

    // Simultaneous accept and pop keeps the count.
    do_reset();
    bus.IN_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin new_data(); cyc(); end
    bus.IN_valid = '0;
    cyc();
    bus.IN_valid = 4'b0001;
    bus.IN_pop   = 1'b1;
    new_data();
    settle(); chk("t4_count_before", bus.OUT_count, 5); tick();
    bus.IN_valid = '0;
    bus.IN_pop   = 1'b0;
    settle();
    chk("t4_count_after", bus.OUT_count, 5);
    chk("t4_valid", bus.OUT_valid, 1);
    tick();

    // Underflow is sticky until reset.
    do_reset();
    bus.IN_pop = 1'b1;
    cyc();
    bus.IN_pop = 1'b0;
    settle();
    chk("t5_count_zero", bus.OUT_count, 0);
    chk("t5_underflow", bus.OUT_underflow, 1);
    tick();
    bus.IN_valid = 4'b1001;
    for (int i = 0; i < 6; i++) begin new_data(); cyc(); end
    settle(); chk("t5_sticky", bus.OUT_underflow, 1); tick();
    do_reset();
    settle(); chk("t5_cleared", bus.OUT_underflow, 0); tick();

    // Reset mid-burst drops the write in flight and all credits.
    do_reset();
    bus.IN_valid = 4'b1111;
    for (int i = 0; i < 40; i++) begin new_data(); cyc(); end
    settle();
    chk("t6_count_40", bus.OUT_count, 40);
    chk("t6_valid_1", bus.OUT_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.IN_valid = 4'b1010;
    new_data();
    settle();
    chk("t6_valid_0", bus.OUT_valid, 0);
    chk("t6_count_0", bus.OUT_count, 0);
    chk("t6_src_0", bus.OUT_src, 0);
    chk("t6_data_0", bus.OUT_data, 0);
    chk("t6_first_grant", bus.OUT_ready, 4'b0010);
    tick();

    // Random traffic with alternating fill/drain bias and rare resets.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.IN_valid = 4'($urandom);
      if (((i / 500) % 2) == 0) bus.IN_pop = ($urandom_range(0, 7) == 0);
      else                      bus.IN_pop = ($urandom_range(0, 7) != 0);
      new_data();
      cyc();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
